// File: rtl/digit_serial_add32.sv
// Byte-serial 32-bit adder: one 8-bit prefix-adder slice is reused for each
// operand byte, LSB first, and the result is offered on a valid/ready port.
module digit_serial_add32 #(
    parameter int N_SLICES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*N_SLICES-1:0]   a,
    input  logic [8*N_SLICES-1:0]   b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*N_SLICES-1:0]   sum,
    output logic                    cout,
    output logic                    busy
);
    localparam int W     = 8 * N_SLICES;
    localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_out_valid;
    logic             r_busy;
    logic [IDX_W-1:0] r_idx;

    logic [7:0]       w_slice_sum;
    logic             w_slice_cout;

    ppa8 u_slice (
        .i_a    (r_a[7:0]),
        .i_b    (r_b[7:0]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Result bytes enter at the top; after N_SLICES shifts byte 0 sits at the bottom.
                    r_sum   <= W'({w_slice_sum, r_sum} >> 8);
                    r_carry <= w_slice_cout;
                    r_a     <= r_a >> 8;
                    r_b     <= r_b >> 8;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// 8-bit Kogge-Stone adder slice; carry-in is folded into the bit-0 generate.
module ppa8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    logic [7:0] w_p;
    logic [7:0] w_gl [4];
    logic [7:0] w_pl [4];

    assign w_p     = i_a ^ i_b;
    assign w_gl[0] = (i_a & i_b) | {7'b0, w_p[0] & i_cin};
    assign w_pl[0] = w_p;

    for (genvar l = 0; l < 3; l++) begin : g_lvl
        for (genvar i = 0; i < 8; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_op
                assign w_gl[l+1][i] = w_gl[l][i] | (w_pl[l][i] & w_gl[l][i-(1<<l)]);
                assign w_pl[l+1][i] = w_pl[l][i] & w_pl[l][i-(1<<l)];
            end else begin : g_pass
                assign w_gl[l+1][i] = w_gl[l][i];
                assign w_pl[l+1][i] = w_pl[l][i];
            end
        end
    end

    // w_gl[3][i] is the carry out of bit i, i.e. the carry into bit i+1.
    assign o_sum  = w_p ^ {w_gl[3][6:0], i_cin};
    assign o_cout = w_gl[3][7];

endmodule

// File: tb/tb_digit_serial_add32.sv
// Directed bench for digit_serial_add32: reset, arithmetic corners,
// backpressure with ignored input, and reset during a running add.
module tb_digit_serial_add32;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    digit_serial_add32 #(.N_SLICES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for out_valid, returning the number of rising edges since acceptance.
    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_add(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic tc, input logic [31:0] es, input logic ec);
        int lat;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEADBEEF;
        b        = 32'hCAFEF00D;
        cin      = 1'b1;
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        wait_result(lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'd4);
        check_eq({tag, "_sum"}, 64'(sum), 64'(es));
        check_eq({tag, "_cout"}, 64'(cout), 64'(ec));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_released"}, 64'({out_valid, in_ready, busy}), 64'b010);
    endtask

    initial begin
        int lat;
        logic seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("in_ready_in_reset", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_sum", 64'(sum), 64'd0);
        check_eq("reset_cout", 64'(cout), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);

        run_add("basic", 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0);
        run_add("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
        run_add("top_ovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        run_add("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        run_add("byte_carry", 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0);

        // Backpressure: hold the result while new operands wait at the input.
        @(negedge clk);
        a        = 32'h11111111;
        b        = 32'h22222222;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        a        = 32'h01020304;
        b        = 32'h10203040;
        cin      = 1'b1;
        wait_result(lat);
        check_eq("bp_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_hold", 64'({out_valid, in_ready, cout, sum}), {29'd0, 1'b1, 1'b0, 1'b0, 32'h33333333});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_in_ready_after", 64'({in_ready, out_valid}), 64'b10);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_second_accept", 64'({busy, in_ready}), 64'b10);
        wait_result(lat);
        check_eq("bp2_latency", 64'(lat), 64'd4);
        check_eq("bp2_sum", 64'(sum), 64'h11223345);
        check_eq("bp2_cout", 64'(cout), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset two cycles into a running add.
        a        = 32'h12345678;
        b        = 32'h00000001;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrun_rst_state", 64'({out_valid, busy, cout, in_ready}), 64'd0);
        check_eq("midrun_rst_sum", 64'(sum), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("midrun_idle", 64'(in_ready), 64'd1);
        seen_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        check_eq("midrun_no_valid", 64'(seen_valid), 64'd0);
        run_add("after_rst", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
